// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and transmit-buffer FSM state type
package uart_pkg;

    localparam int UART_DATA_W    = 8;
    localparam int UART_TXF_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } uart_txf_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - circular byte FIFO with count and full/empty flags
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_TXF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [UART_DATA_W-1:0] i_push_data,
    input  logic                   i_pop,
    output logic [UART_DATA_W-1:0] o_rd_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [AW:0]            o_count
);

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [UART_DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   w_do_push;
    logic                   w_do_pop;

    // Both guards use the pre-edge count, so a full push is dropped even if a pop lands on the same edge.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - transmit byte buffer feeding the UART transmitter handshake
// Optional level/half outputs are enabled by defining UART_TXF_LEVEL_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int DEPTH = UART_TXF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [UART_DATA_W-1:0] wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic                   empty,
    output logic                   busy,
    output logic                   overflow,
    output logic [UART_DATA_W-1:0] tx_din,
    output logic                   tx_enable,
    input  logic                   tx_done
`ifdef UART_TXF_LEVEL_EN
    ,
    output logic [AW:0]            level,
    output logic                   half
`endif
);

    uart_txf_state_t        r_state;
    logic [UART_DATA_W-1:0] r_tx_din;
    logic                   r_tx_enable;
    logic                   r_overflow;
    logic [UART_DATA_W-1:0] w_rd_data;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;

    assign w_pop = (r_state == IDLE) && !w_empty;

`ifdef UART_TXF_LEVEL_EN
    localparam logic [AW:0] CNT_HALF = (AW+1)'(DEPTH / 2);
    logic [AW:0] w_count;

    assign level = w_count;
    assign half  = (w_count >= CNT_HALF);
`endif

    uart_fifo_mem #(
        .DEPTH       (DEPTH)
    ) u_mem (
        .clk         (clk),
        .rst         (rst),
        .i_push      (wr_en),
        .i_push_data (wr_data),
        .i_pop       (w_pop),
        .o_rd_data   (w_rd_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
`ifdef UART_TXF_LEVEL_EN
        .o_count     (w_count)
`else
        .o_count     ()
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_tx_din    <= '0;
            r_tx_enable <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (wr_en && w_full) r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_tx_din    <= w_rd_data;
                        r_tx_enable <= 1'b1;
                        r_state     <= START;
                    end
                end
                START: begin
                    r_tx_enable <= 1'b0;
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (tx_done) r_state <= IDLE;
                end
                default: begin
                    r_tx_enable <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign full      = w_full;
    assign empty     = w_empty;
    assign busy      = (r_state != IDLE);
    assign overflow  = r_overflow;
    assign tx_din    = r_tx_din;
    assign tx_enable = r_tx_enable;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed self-checking bench for uart_tx_fifo
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic       empty;
    logic       busy;
    logic       overflow;
    logic [7:0] tx_din;
    logic       tx_enable;
    logic       tx_done;
`ifdef UART_TXF_LEVEL_EN
    logic [4:0] level;
    logic       half;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_data   (wr_data),
        .wr_en     (wr_en),
        .full      (full),
        .empty     (empty),
        .busy      (busy),
        .overflow  (overflow),
        .tx_din    (tx_din),
        .tx_enable (tx_enable),
        .tx_done   (tx_done)
`ifdef UART_TXF_LEVEL_EN
        ,
        .level     (level),
        .half      (half)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    // Finishes the in-flight frame and returns what the next start pulse carries.
    task automatic frame_step(output logic busy_after_done, output logic en_at_start,
                              output logic [7:0] din_at_start, output logic en_after);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        busy_after_done = busy;
        tick();
        en_at_start  = tx_enable;
        din_at_start = tx_din;
        tick();
        en_after = tx_enable;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (empty !== 1'b1)    begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
        checks++; if (full !== 1'b0)     begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (tx_enable !== 1'b0) begin failures++; $display("FAIL reset_tx_enable got=%b exp=0", tx_enable); end
        checks++; if (tx_din !== 8'h00)  begin failures++; $display("FAIL reset_tx_din got=%h exp=00", tx_din); end
    endtask

    task automatic test_single();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_done_ignored got=%b exp=0", busy); end
        write_byte(8'hA5);
        checks++; if (empty !== 1'b0)     begin failures++; $display("FAIL single_e0_empty got=%b exp=0", empty); end
        checks++; if (tx_enable !== 1'b0) begin failures++; $display("FAIL single_e0_enable got=%b exp=0", tx_enable); end
        tick();
        checks++; if (tx_din !== 8'hA5)   begin failures++; $display("FAIL single_tx_din got=%h exp=a5", tx_din); end
        checks++; if (tx_enable !== 1'b1) begin failures++; $display("FAIL single_enable got=%b exp=1", tx_enable); end
        checks++; if (busy !== 1'b1)      begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
        checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL single_e1_empty got=%b exp=1", empty); end
        tick();
        checks++; if (tx_enable !== 1'b0) begin failures++; $display("FAIL single_enable_pulse got=%b exp=0", tx_enable); end
        checks++; if (tx_din !== 8'hA5)   begin failures++; $display("FAIL single_din_hold got=%h exp=a5", tx_din); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_done_idle got=%b exp=0", busy); end
    endtask

    task automatic test_burst();
        logic       b_done;
        logic       en_s;
        logic [7:0] din_s;
        logic       en_a;
        for (int i = 0; i < 16; i++) begin
            write_byte(8'(i));
            checks++; if (full !== 1'b0) begin failures++; $display("FAIL burst_full_early i=%0d got=%b exp=0", i, full); end
        end
        write_byte(8'h10);
        checks++; if (full !== 1'b1)     begin failures++; $display("FAIL burst_full got=%b exp=1", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL burst_no_overflow got=%b exp=0", overflow); end
        write_byte(8'hEE);
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL burst_overflow got=%b exp=1", overflow); end
        checks++; if (tx_din !== 8'h00)  begin failures++; $display("FAIL burst_first_din got=%h exp=00", tx_din); end
        for (int i = 1; i <= 16; i++) begin
            frame_step(b_done, en_s, din_s, en_a);
            checks++; if (b_done !== 1'b0) begin failures++; $display("FAIL burst_gap_idle i=%0d got=%b exp=0", i, b_done); end
            checks++; if (en_s !== 1'b1 || din_s !== 8'(i)) begin
                failures++; $display("FAIL burst_order i=%0d got en=%b din=%h exp en=1 din=%h", i, en_s, din_s, 8'(i));
            end
            checks++; if (en_a !== 1'b0) begin failures++; $display("FAIL burst_pulse_width i=%0d got=%b exp=0", i, en_a); end
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL burst_drained got empty=%b busy=%b exp empty=1 busy=0", empty, busy);
        end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
        checks++; if (busy !== 1'b1 || empty !== 1'b0) begin
            failures++; $display("FAIL mid_pre got busy=%b empty=%b exp busy=1 empty=0", busy, empty);
        end
        do_reset();
        checks++; if (empty !== 1'b1)     begin failures++; $display("FAIL mid_empty got=%b exp=1", empty); end
        checks++; if (tx_enable !== 1'b0) begin failures++; $display("FAIL mid_enable got=%b exp=0", tx_enable); end
        checks++; if (overflow !== 1'b0)  begin failures++; $display("FAIL mid_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL mid_busy got=%b exp=0", busy); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || tx_enable !== 1'b0) begin
            failures++; $display("FAIL mid_late_done got busy=%b en=%b exp 0 0", busy, tx_enable);
        end
        write_byte(8'h7E);
        tick();
        checks++; if (tx_din !== 8'h7E || tx_enable !== 1'b1) begin
            failures++; $display("FAIL mid_recover got din=%h en=%b exp din=7e en=1", tx_din, tx_enable);
        end
        tick();
    endtask

    task automatic test_simul_wrap();
        logic       b_done;
        logic       en_s;
        logic [7:0] din_s;
        logic       en_a;
        do_reset();
        for (int i = 0; i < 15; i++) write_byte(8'h40 + 8'(i));
        for (int i = 1; i <= 13; i++) begin
            frame_step(b_done, en_s, din_s, en_a);
            checks++; if (din_s !== 8'h40 + 8'(i)) begin
                failures++; $display("FAIL wrap_drain i=%0d got=%h exp=%h", i, din_s, 8'h40 + 8'(i));
            end
        end
        write_byte(8'h4F);
        write_byte(8'h50);
        frame_step(b_done, en_s, din_s, en_a);
        checks++; if (din_s !== 8'h4E) begin failures++; $display("FAIL wrap_pre got=%h exp=4e", din_s); end
        write_byte(8'h51);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        write_byte(8'h52);
        checks++; if (tx_din !== 8'h4F || tx_enable !== 1'b1) begin
            failures++; $display("FAIL wrap_simul got din=%h en=%b exp din=4f en=1", tx_din, tx_enable);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            frame_step(b_done, en_s, din_s, en_a);
            checks++; if (en_s !== 1'b1 || din_s !== 8'h50 + 8'(i)) begin
                failures++; $display("FAIL wrap_tail i=%0d got en=%b din=%h exp en=1 din=%h", i, en_s, din_s, 8'h50 + 8'(i));
            end
        end
        checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty got=%b exp=1", empty); end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || tx_enable !== 1'b0) begin
            failures++; $display("FAIL wrap_final got busy=%b en=%b exp 0 0", busy, tx_enable);
        end
    endtask

`ifdef UART_TXF_LEVEL_EN
    task automatic test_level();
        do_reset();
        for (int i = 0; i < 9; i++) write_byte(8'h90 + 8'(i));
        checks++; if (level !== 5'd8) begin failures++; $display("FAIL level_count got=%0d exp=8", level); end
        checks++; if (half !== 1'b1)  begin failures++; $display("FAIL level_half got=%b exp=1", half); end
    endtask
`endif

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        tx_done = 1'b0;
        tick();
        test_reset();
        test_single();
        test_burst();
        test_reset_mid();
        test_simul_wrap();
`ifdef UART_TXF_LEVEL_EN
        test_level();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
